// File: rtl/game_flow_ctrl.sv
// Round sequencer for the fighting game: MENU -> COUNTDOWN -> FIGHT -> GAME_OVER -> MENU.
// Owns the one-second tick, the BCD round timer, the winner decision and the menu re-arm pulse.
module game_flow_ctrl #(
    parameter int SEC_CYCLES  = 25_000_000,
    parameter int COUNTDOWN_S = 3,
    parameter int ROUND_S     = 99,
    parameter int OVER_S      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_game,
    input  logic       sw0_mode_select,
    input  logic       p1_ko,
    input  logic       p2_ko,
    input  logic [6:0] p1_health,
    input  logic [6:0] p2_health,
    output logic [1:0] state,
    output logic [1:0] screen_sel,
    output logic       game_run,
    output logic       round_reset,
    output logic       menu_rearm,
    output logic       mode_2p,
    output logic [3:0] countdown_val,
    output logic [3:0] timer_tens,
    output logic [3:0] timer_ones,
    output logic [1:0] winner
);

    localparam logic [1:0] MENU      = 2'd0;
    localparam logic [1:0] COUNTDOWN = 2'd1;
    localparam logic [1:0] FIGHT     = 2'd2;
    localparam logic [1:0] GAME_OVER = 2'd3;

    localparam int         CW        = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(SEC_CYCLES - 1);
    localparam logic [3:0] ROUND_TENS = 4'(ROUND_S / 10);
    localparam logic [3:0] ROUND_ONES = 4'(ROUND_S % 10);

    logic [CW-1:0] tick_cnt, tick_cnt_n;
    logic [3:0]    over_left, over_left_n;
    logic          tick;

    logic [1:0] state_n, winner_n;
    logic       round_reset_n, menu_rearm_n, mode_2p_n;
    logic [3:0] countdown_n, tens_n, ones_n;
    logic       decided;
    logic [1:0] decided_winner;

    assign tick       = (tick_cnt == TICK_LAST);
    assign screen_sel = state;

    always_comb begin
        state_n        = state;
        winner_n       = winner;
        mode_2p_n      = mode_2p;
        countdown_n    = countdown_val;
        tens_n         = timer_tens;
        ones_n         = timer_ones;
        over_left_n    = over_left;
        round_reset_n  = 1'b0;
        menu_rearm_n   = 1'b0;
        decided        = 1'b0;
        decided_winner = 2'd0;

        case (state)
            MENU: begin
                if (start_game) begin
                    state_n       = COUNTDOWN;
                    mode_2p_n     = sw0_mode_select;
                    countdown_n   = 4'(COUNTDOWN_S);
                    tens_n        = ROUND_TENS;
                    ones_n        = ROUND_ONES;
                    winner_n      = 2'd0;
                    round_reset_n = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (tick) begin
                    if (countdown_val <= 4'd1) begin
                        countdown_n = 4'd0;
                        state_n     = FIGHT;
                    end else begin
                        countdown_n = countdown_val - 4'd1;
                    end
                end
            end
            FIGHT: begin
                // KO outranks the tick: the timer is left untouched on a KO edge.
                if (p1_ko && p2_ko) begin
                    decided        = 1'b1;
                    decided_winner = 2'd3;
                end else if (p1_ko) begin
                    decided        = 1'b1;
                    decided_winner = 2'd2;
                end else if (p2_ko) begin
                    decided        = 1'b1;
                    decided_winner = 2'd1;
                end else if (tick) begin
                    if (timer_tens == 4'd0 && timer_ones <= 4'd1) begin
                        ones_n  = 4'd0;
                        decided = 1'b1;
                        if (p1_health > p2_health)
                            decided_winner = 2'd1;
                        else if (p2_health > p1_health)
                            decided_winner = 2'd2;
                        else
                            decided_winner = 2'd3;
                    end else if (timer_ones == 4'd0) begin
                        ones_n = 4'd9;
                        tens_n = timer_tens - 4'd1;
                    end else begin
                        ones_n = timer_ones - 4'd1;
                    end
                end
                if (decided) begin
                    winner_n    = decided_winner;
                    state_n     = GAME_OVER;
                    over_left_n = 4'(OVER_S);
                end
            end
            default: begin
                if (tick) begin
                    if (over_left <= 4'd1) begin
                        over_left_n  = 4'd0;
                        state_n      = MENU;
                        menu_rearm_n = 1'b1;
                    end else begin
                        over_left_n = over_left - 4'd1;
                    end
                end
            end
        endcase

        // Restarting the count on every transition aligns the first tick to state entry.
        if (state_n != state || tick)
            tick_cnt_n = '0;
        else
            tick_cnt_n = tick_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= MENU;
            game_run      <= 1'b0;
            round_reset   <= 1'b0;
            menu_rearm    <= 1'b0;
            mode_2p       <= 1'b0;
            countdown_val <= '0;
            timer_tens    <= '0;
            timer_ones    <= '0;
            winner        <= '0;
            tick_cnt      <= '0;
            over_left     <= '0;
        end else begin
            state         <= state_n;
            game_run      <= (state_n == FIGHT);
            round_reset   <= round_reset_n;
            menu_rearm    <= menu_rearm_n;
            mode_2p       <= mode_2p_n;
            countdown_val <= countdown_n;
            timer_tens    <= tens_n;
            timer_ones    <= ones_n;
            winner        <= winner_n;
            tick_cnt      <= tick_cnt_n;
            over_left     <= over_left_n;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with SEC_CYCLES=4, COUNTDOWN_S=3, ROUND_S=12, OVER_S=2.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_game;
    logic       sw0_mode_select;
    logic       p1_ko, p2_ko;
    logic [6:0] p1_health, p2_health;
    logic [1:0] state, screen_sel, winner;
    logic       game_run, round_reset, menu_rearm, mode_2p;
    logic [3:0] countdown_val, timer_tens, timer_ones;

    int total = 0;
    int bad   = 0;

    game_flow_ctrl #(
        .SEC_CYCLES (4),
        .COUNTDOWN_S(3),
        .ROUND_S    (12),
        .OVER_S     (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_game     (start_game),
        .sw0_mode_select(sw0_mode_select),
        .p1_ko          (p1_ko),
        .p2_ko          (p2_ko),
        .p1_health      (p1_health),
        .p2_health      (p2_health),
        .state          (state),
        .screen_sel     (screen_sel),
        .game_run       (game_run),
        .round_reset    (round_reset),
        .menu_rearm     (menu_rearm),
        .mode_2p        (mode_2p),
        .countdown_val  (countdown_val),
        .timer_tens     (timer_tens),
        .timer_ones     (timer_ones),
        .winner         (winner)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic mode);
        sw0_mode_select = mode;
        start_game = 1'b1;
        step(1);
        start_game = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start_game = 1'b0; sw0_mode_select = 1'b0;
        p1_ko = 1'b0; p2_ko = 1'b0; p1_health = 7'd40; p2_health = 7'd55;

        // reset
        step(3);
        chk("rst_state", state, 0);
        chk("rst_sel", screen_sel, 0);
        chk("rst_run", game_run, 0);
        chk("rst_rr", round_reset, 0);
        chk("rst_mr", menu_rearm, 0);
        chk("rst_mode", mode_2p, 0);
        chk("rst_cd", countdown_val, 0);
        chk("rst_tens", timer_tens, 0);
        chk("rst_ones", timer_ones, 0);
        chk("rst_win", winner, 0);
        reset = 1'b1;
        step(1);

        // run 1: start in 2P, countdown, time-out with p2 healthier
        start(1'b1);
        chk("st_state", state, 1);
        chk("st_sel", screen_sel, 1);
        chk("st_mode", mode_2p, 1);
        chk("st_rr", round_reset, 1);
        chk("st_cd", countdown_val, 3);
        chk("st_tens", timer_tens, 1);
        chk("st_ones", timer_ones, 2);
        step(1);
        chk("rr_drop", round_reset, 0);
        chk("cd3", countdown_val, 3);
        step(3);
        chk("cd2", countdown_val, 2);
        step(3);
        chk("cd2_hold", countdown_val, 2);
        step(1);
        chk("cd1", countdown_val, 1);
        step(3);
        chk("cd1_state", state, 1);
        chk("cd1_run", game_run, 0);
        step(1);
        chk("cd0", countdown_val, 0);
        chk("fight_state", state, 2);
        chk("fight_run", game_run, 1);
        step(3);
        chk("t12_tens", timer_tens, 1);
        chk("t12_ones", timer_ones, 2);
        step(1);
        for (int k = 1; k <= 11; k++) begin
            chk("tmr_tens", timer_tens, (12 - k) / 10);
            chk("tmr_ones", timer_ones, (12 - k) % 10);
            chk("tmr_state", state, 2);
            if (k < 11) step(4);
        end
        step(3);
        chk("to_pre_state", state, 2);
        step(1);
        chk("to_state", state, 3);
        chk("to_win", winner, 2);
        chk("to_run", game_run, 0);
        chk("to_tens", timer_tens, 0);
        chk("to_ones", timer_ones, 0);

        // start ignored in GAME_OVER, then return to menu
        step(1);
        start_game = 1'b1;
        step(1);
        start_game = 1'b0;
        chk("go_ign_state", state, 3);
        chk("go_ign_rr", round_reset, 0);
        step(5);
        chk("go_hold", state, 3);
        step(1);
        chk("menu_state", state, 0);
        chk("menu_mr", menu_rearm, 1);
        chk("menu_win", winner, 2);
        step(1);
        chk("menu_mr_drop", menu_rearm, 0);
        chk("menu_win2", winner, 2);

        // run 2: equal health time-out
        p1_health = 7'd50; p2_health = 7'd50;
        start(1'b0);
        chk("r2_mode", mode_2p, 0);
        chk("r2_win_clr", winner, 0);
        step(12);
        chk("r2_fight", state, 2);
        step(48);
        chk("r2_state", state, 3);
        chk("r2_win", winner, 3);
        step(8);
        chk("r2_menu", state, 0);
        step(1);

        // run 3: p1 KO on the same edge as a tick with timer at 05
        start(1'b0);
        step(12);
        step(31);
        chk("r3_t05_tens", timer_tens, 0);
        chk("r3_t05_ones", timer_ones, 5);
        p1_ko = 1'b1;
        step(1);
        p1_ko = 1'b0;
        chk("r3_state", state, 3);
        chk("r3_win", winner, 2);
        chk("r3_run", game_run, 0);
        chk("r3_tens", timer_tens, 0);
        chk("r3_ones", timer_ones, 5);
        step(8);
        chk("r3_menu", state, 0);
        step(1);

        // run 4: KO ignored in countdown, then double KO
        start(1'b1);
        step(2);
        p1_ko = 1'b1;
        step(1);
        p1_ko = 1'b0;
        chk("r4_cd_ko", state, 1);
        step(9);
        chk("r4_fight", state, 2);
        step(2);
        p1_ko = 1'b1; p2_ko = 1'b1;
        step(1);
        p1_ko = 1'b0; p2_ko = 1'b0;
        chk("r4_state", state, 3);
        chk("r4_win", winner, 3);
        step(8);
        chk("r4_mr", menu_rearm, 1);
        step(1);

        // run 5: p2 KO gives P1 the win
        start(1'b0);
        step(12);
        step(5);
        p2_ko = 1'b1;
        step(1);
        p2_ko = 1'b0;
        chk("r5_win", winner, 1);
        chk("r5_state", state, 3);
        step(9);

        // run 6: reset mid-round at timer 07
        start(1'b0);
        step(12);
        step(20);
        chk("r6_t07", {timer_tens, timer_ones}, 8'h07);
        reset = 1'b0;
        step(1);
        chk("r6_state", state, 0);
        chk("r6_run", game_run, 0);
        chk("r6_tens", timer_tens, 0);
        chk("r6_ones", timer_ones, 0);
        chk("r6_win", winner, 0);
        chk("r6_rr", round_reset, 0);
        chk("r6_mr", menu_rearm, 0);
        reset = 1'b1;
        step(1);
        chk("r6_mr_after", menu_rearm, 0);
        chk("r6_rr_after", round_reset, 0);
        chk("r6_state_after", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for the DE1-SoC fighting game. It owns the round flow MENU -> COUNTDOWN -> FIGHT -> GAME_OVER -> MENU. It consumes the menu screen's one-cycle `start_game` pulse and the fighters' KO and health status, and drives the VGA screen-select mux, the fighter-logic run enable, the BCD round timer and the winner code. It also generates a re-arm pulse so the menu screen can accept a new start.

## Interface
- `SEC_CYCLES`, default 25_000_000: clock cycles per one-second tick.
- `COUNTDOWN_S`, default 3: pre-fight countdown length in seconds, range 1..9.
- `ROUND_S`, default 99: round length in seconds, range 1..99.
- `OVER_S`, default 5: seconds spent in GAME_OVER before returning to MENU, range 1..15.
- `clk`  in  1  system/pixel clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on rising `clk`).
- `start_game`  in  1  one-cycle pulse from the menu screen.
- `sw0_mode_select`  in  1  0 = 1P, 1 = 2P.
- `p1_ko`, `p2_ko`  in  1 each  level; fighter health is zero.
- `p1_health`, `p2_health`  in  7 each  unsigned health, used only at time-out.
- `state`  out  2  0 = MENU, 1 = COUNTDOWN, 2 = FIGHT, 3 = GAME_OVER.
- `screen_sel`  out  2  VGA mux select; always equal to `state`.
- `game_run`  out  1  high only in FIGHT; enables fighter movement and damage.
- `round_reset`  out  1  one-cycle pulse that restores fighter positions and health.
- `menu_rearm`  out  1  one-cycle pulse, active-high, wired to the menu screen's reset.
- `mode_2p`  out  1  `sw0_mode_select` latched at game start.
- `countdown_val`  out  4  remaining countdown seconds.
- `timer_tens`, `timer_ones`  out  4 each  BCD round timer.
- `winner`  out  2  0 = none, 1 = P1, 2 = P2, 3 = draw.

## Operation
- Reset (while `reset` = 0) sets: `state` = MENU, `game_run` = 0, `round_reset` = 0, `menu_rearm` = 0, `mode_2p` = 0, `countdown_val` = 0, `timer_tens`/`timer_ones` = 0/0, `winner` = 0, tick counter = 0.
- Tick counter: counts 0..SEC_CYCLES-1 and wraps. `tick` is high for the cycle in which the count is SEC_CYCLES-1. The counter clears to 0 on every state transition, so the first tick in a state occurs exactly SEC_CYCLES cycles after entry.
- MENU: when `start_game` = 1, go to COUNTDOWN. On that same edge:
  - latch `mode_2p` from `sw0_mode_select`;
  - load `countdown_val` = COUNTDOWN_S;
  - load the timer with the BCD value of ROUND_S;
  - clear `winner` to 0;
  - pulse `round_reset`.
- `start_game` is ignored in every other state.
- COUNTDOWN: on each tick, `countdown_val` decrements. If the tick arrives while `countdown_val` = 1, it becomes 0 and the state goes to FIGHT. KO inputs are ignored in this state.
- FIGHT: `game_run` = 1. Conditions are checked every cycle in this priority order:
  - `p1_ko` and `p2_ko` both high -> `winner` = 3.
  - `p1_ko` high -> `winner` = 2.
  - `p2_ko` high -> `winner` = 1.
  - Otherwise on tick: decrement the BCD timer (ones 0 -> 9 with a tens borrow). If the timer was 00:01, it becomes 00 and the winner is decided by health: larger `p1_health` -> 1, larger `p2_health` -> 2, equal -> 3.
- Any winner decision moves the state to GAME_OVER on the same edge. A KO wins over a tick in the same cycle, and the timer is not decremented on that edge.
- GAME_OVER: `game_run` = 0 and `winner` holds. After OVER_S ticks, go to MENU and pulse `menu_rearm` on that edge. `winner` stays valid until the next start.
- The BCD timer never underflows below 00. The tens digit is only ever 0..9.

## Timing
- All outputs are registered and change only on rising `clk`.
- `start_game` high on edge N results in `state` = 1 and `round_reset` = 1 after edge N. `round_reset` returns to 0 after edge N+1.
- COUNTDOWN lasts exactly COUNTDOWN_S × SEC_CYCLES cycles. FIGHT with no KO lasts ROUND_S × SEC_CYCLES cycles. GAME_OVER lasts OVER_S × SEC_CYCLES cycles.
- KO latency: `p1_ko` sampled high on edge N gives `state` = 3, `game_run` = 0 and `winner` = 2 after edge N.
- Reset asserted mid-round takes effect on the next edge: all outputs go to their reset values and no `round_reset` or `menu_rearm` pulse is emitted.
- `menu_rearm` pulse: one cycle, immediately after the transition into MENU.

## Test plan
Parameters for all scenarios: SEC_CYCLES = 4, COUNTDOWN_S = 3, ROUND_S = 12, OVER_S = 2.

- **Reset and start:** hold `reset` = 0 for 3 cycles, release, then pulse `start_game` with `sw0_mode_select` = 1 -> `state` = 1, `mode_2p` = 1, `round_reset` high for 1 cycle, `countdown_val` = 3, timer = 1/2.
- **Countdown:** after start, `countdown_val` reads 3, 2, 1 at 4-cycle spacing, then 0 with `state` = 2 exactly 12 cycles after entry; `game_run` = 1.
- **Time-out:** no KO, `p1_health` = 40, `p2_health` = 55 -> timer sequence 12, 11, 10, 09, ..., 00; `state` = 3 and `winner` = 2 at 48 cycles into FIGHT. Repeat with equal health -> `winner` = 3.
- **Simultaneous events:** assert `p1_ko` on the same cycle as a tick with timer at 05 -> `winner` = 2, timer stays 05. Assert `p1_ko` and `p2_ko` together -> `winner` = 3.
- **Return to menu:** from GAME_OVER, wait 8 cycles -> `state` = 0, `menu_rearm` high for 1 cycle, `winner` still holds. A `start_game` pulse during GAME_OVER causes no state change.
- **Mid-round reset:** drive `reset` = 0 during FIGHT at timer 07 -> after one edge, `state` = 0, `game_run` = 0, timer = 00, `winner` = 0, and no pulses are emitted.
